// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the EX/MEM pipeline boundary:
//   - default datapath and register-number widths
//   - bit positions of the architectural condition flags {C,V,N,Z}
//   - the MEM/WB control word and the all-zero bubble value
//   - a helper for the per-flag masked write
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;

  localparam int FLG_C = 3;
  localparam int FLG_V = 2;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 0;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = 4'b0000;

  // The select is a known enable bit, so an X on a data bit whose enable is
  // low never reaches the stored flag.
  function automatic logic flag_bit_next(input logic we, input logic d, input logic q);
    return we ? d : q;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_if.sv
// -----------------------------------------------------------------------------
// ex_mem_pipe_reg_if
// Bundle of the EX-side inputs and MEM-side outputs of the EX/MEM register.
//   master : EX stage / testbench side (drives ex_*, observes mem_* and flags)
//   slave  : the pipeline register (consumes ex_*, drives mem_* and flags)
// -----------------------------------------------------------------------------
interface ex_mem_pipe_reg_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          ex_valid;
  logic [DW-1:0] ex_result;
  logic [DW-1:0] ex_store_data;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic [3:0]    ex_flags;
  logic [3:0]    ex_flag_we;

  logic          mem_valid;
  logic [DW-1:0] mem_result;
  logic [DW-1:0] mem_store_data;
  logic [RW-1:0] mem_rd;
  logic          mem_reg_write;
  logic          mem_mem_read;
  logic          mem_mem_write;
  logic [3:0]    flags;

  modport master (
    output ex_valid, ex_result, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_flags, ex_flag_we,
    input  mem_valid, mem_result, mem_store_data, mem_rd,
           mem_reg_write, mem_mem_read, mem_mem_write, flags
  );

  modport slave (
    input  ex_valid, ex_result, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_flags, ex_flag_we,
    output mem_valid, mem_result, mem_store_data, mem_rd,
           mem_reg_write, mem_mem_read, mem_mem_write, flags
  );
endinterface

// File: rtl/flag_reg.sv
// -----------------------------------------------------------------------------
// flag_reg
// Architectural {C,V,N,Z} register with a per-bit write mask.
//   clk   : clock
//   reset : synchronous active-high reset, clears all flags
//   en    : update enable (a real, non-stalled, non-flushed instruction)
//   d     : candidate flag values {C,V,N,Z}
//   we    : per-flag write enable, same bit order as d
//   q     : registered flags
// -----------------------------------------------------------------------------
module flag_reg
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] d,
  input  logic [3:0] we,
  output logic [3:0] q
);

  logic [3:0] q_r;
  logic [3:0] next_s;

  // Next flag value: each bit written only when both en and its mask bit are set.
  always_comb begin
    next_s = q_r;
    if (en) begin
      next_s[FLG_C] = flag_bit_next(we[FLG_C], d[FLG_C], q_r[FLG_C]);
      next_s[FLG_V] = flag_bit_next(we[FLG_V], d[FLG_V], q_r[FLG_V]);
      next_s[FLG_N] = flag_bit_next(we[FLG_N], d[FLG_N], q_r[FLG_N]);
      next_s[FLG_Z] = flag_bit_next(we[FLG_Z], d[FLG_Z], q_r[FLG_Z]);
    end else begin
      next_s = q_r;
    end
  end

  // Flag storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= 4'b0000;
    end else begin
      q_r <= next_s;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// -----------------------------------------------------------------------------
// ex_mem_pipe_reg
// EX/MEM pipeline register plus architectural condition flags.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset (wins over stall and flush)
//   stall : hold every register, flags included (flush ignored)
//   flush : load a bubble instead of the EX instruction; flags untouched
//   bus   : ex_* inputs from EX, mem_* outputs to MEM, flags
// Data fields (result, store data, rd) load on every non-stalled cycle; only
// the valid/control word is squashed on a bubble.
// -----------------------------------------------------------------------------
module ex_mem_pipe_reg
  import mips_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  ex_mem_pipe_reg_if.slave   bus
);

  logic [DW-1:0] result_r;
  logic [DW-1:0] store_data_r;
  logic [RW-1:0] rd_r;
  ctrl_t         ctrl_r;
  ctrl_t         ctrl_next_s;
  logic          flag_en_s;
  logic [3:0]    flags_s;

  // Control word to load: a bubble when flushed or when EX holds no instruction.
  always_comb begin
    ctrl_next_s = CTRL_BUBBLE;
    if (bus.ex_valid && !flush) begin
      ctrl_next_s.valid     = 1'b1;
      ctrl_next_s.reg_write = bus.ex_reg_write;
      ctrl_next_s.mem_read  = bus.ex_mem_read;
      ctrl_next_s.mem_write = bus.ex_mem_write;
    end else begin
      ctrl_next_s = CTRL_BUBBLE;
    end
  end

  assign flag_en_s = !stall && !flush && bus.ex_valid;

  // Pipeline register: reset > stall (hold) > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_r     <= {DW{1'b0}};
      store_data_r <= {DW{1'b0}};
      rd_r         <= {RW{1'b0}};
      ctrl_r       <= CTRL_BUBBLE;
    end else if (stall) begin
      result_r     <= result_r;
      store_data_r <= store_data_r;
      rd_r         <= rd_r;
      ctrl_r       <= ctrl_r;
    end else begin
      result_r     <= bus.ex_result;
      store_data_r <= bus.ex_store_data;
      rd_r         <= bus.ex_rd;
      ctrl_r       <= ctrl_next_s;
    end
  end

  flag_reg u_flag_reg (
    .clk   (clk),
    .reset (reset),
    .en    (flag_en_s),
    .d     (bus.ex_flags),
    .we    (bus.ex_flag_we),
    .q     (flags_s)
  );

  assign bus.mem_valid      = ctrl_r.valid;
  assign bus.mem_reg_write  = ctrl_r.reg_write;
  assign bus.mem_mem_read   = ctrl_r.mem_read;
  assign bus.mem_mem_write  = ctrl_r.mem_write;
  assign bus.mem_result     = result_r;
  assign bus.mem_store_data = store_data_r;
  assign bus.mem_rd         = rd_r;
  assign bus.flags          = flags_s;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_ex_mem_pipe_reg
// Directed vector table for the EX/MEM register corner cases, followed by a
// randomized run checked against a behavioural model of the register rules.
// -----------------------------------------------------------------------------
module tb_ex_mem_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [3:0]  flags;
  } outs_t;

  typedef struct {
    string       name;
    logic        rst;
    logic        stl;
    logic        fl;
    logic        v;
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [3:0]  fin;
    logic [3:0]  we;
    outs_t       exp;
  } vec_t;

  logic clk;
  logic reset;
  logic stall;
  logic flush;

  int errors = 0;
  int checks = 0;

  vec_t vq[$];

  ex_mem_pipe_reg_if #(.DW(32), .RW(5)) bus ();

  ex_mem_pipe_reg #(.DW(32), .RW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t get_outs();
    outs_t o;
    o.valid  = bus.mem_valid;
    o.result = bus.mem_result;
    o.sd     = bus.mem_store_data;
    o.rd     = bus.mem_rd;
    o.rw     = bus.mem_reg_write;
    o.mr     = bus.mem_mem_read;
    o.mw     = bus.mem_mem_write;
    o.flags  = bus.flags;
    return o;
  endfunction

  task automatic drive(input logic r, input logic s, input logic f, input logic v,
                       input logic [31:0] res, input logic [31:0] sd, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw,
                       input logic [3:0] fin, input logic [3:0] we);
    reset              = r;
    stall              = s;
    flush              = f;
    bus.ex_valid       = v;
    bus.ex_result      = res;
    bus.ex_store_data  = sd;
    bus.ex_rd          = rd;
    bus.ex_reg_write   = rw;
    bus.ex_mem_read    = mr;
    bus.ex_mem_write   = mw;
    bus.ex_flags       = fin;
    bus.ex_flag_we     = we;
  endtask

  task automatic check(input string name, input outs_t exp);
    outs_t got;
    got = get_outs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got v=%0b res=%h sd=%h rd=%0d rw=%0b mr=%0b mw=%0b flags=%b; want v=%0b res=%h sd=%h rd=%0d rw=%0b mr=%0b mw=%0b flags=%b",
               name, got.valid, got.result, got.sd, got.rd, got.rw, got.mr, got.mw, got.flags,
               exp.valid, exp.result, exp.sd, exp.rd, exp.rw, exp.mr, exp.mw, exp.flags);
    end
  endtask

  task automatic add_vec(input string name, input logic r, input logic s, input logic f,
                         input logic v, input logic [31:0] res, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                         input logic [3:0] fin, input logic [3:0] we, input outs_t exp);
    vec_t t;
    t.name = name; t.rst = r; t.stl = s; t.fl = f; t.v = v;
    t.res = res; t.sd = sd; t.rd = rd; t.rw = rw; t.mr = mr; t.mw = mw;
    t.fin = fin; t.we = we; t.exp = exp;
    vq.push_back(t);
  endtask

  initial begin
    outs_t zero_o;
    outs_t o3;
    outs_t o9;
    outs_t o13;
    outs_t m;
    logic r, s, f, v, rw, mr, mw;
    logic [31:0] res, sd;
    logic [4:0] rd;
    logic [3:0] fin, we;

    zero_o = {1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000};
    o3     = {1'b1, 32'h1234_5678, 32'hAAAA_5555, 5'd3, 1'b1, 1'b1, 1'b0, 4'b0101};
    o9     = {1'b1, 32'h0000_2222, 32'h0000_3333, 5'd5, 1'b1, 1'b0, 1'b0, 4'b1011};
    o13    = {1'b1, 32'h0000_8888, 32'h0000_0000, 5'd2, 1'b1, 1'b0, 1'b0, 4'b0010};

    // name, rst, stall, flush, valid, result, store, rd, rw, mr, mw, flags, we, expected
    add_vec("reset_a", 1'b1, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 32'h1357_9BDF, 5'd31, 1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111, zero_o);
    add_vec("reset_b", 1'b1, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 32'h1357_9BDF, 5'd31, 1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111, zero_o);
    add_vec("load_f0_v_masked", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00F0, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 4'b1x00, 4'b1011,
            {1'b1, 32'h0000_00F0, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 4'b1000});
    add_vec("load_1234", 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'hAAAA_5555, 5'd3, 1'b1, 1'b1, 1'b0, 4'b0101, 4'b1111, o3);
    for (int i = 0; i < 3; i++)
      add_vec($sformatf("stall_hold_%0d", i), 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd9, 1'b0, 1'b0, 1'b1, 4'b1010, 4'b1111, o3);
    add_vec("stall_release", 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd9, 1'b0, 1'b0, 1'b1, 4'b1010, 4'b1111,
            {1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd9, 1'b0, 1'b0, 1'b1, 4'b1010});
    add_vec("flush_bubble", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_1111, 32'h0000_2222, 5'd4, 1'b1, 1'b0, 1'b1, 4'b0101, 4'b1111,
            {1'b0, 32'h0000_1111, 32'h0000_2222, 5'd4, 1'b0, 1'b0, 1'b0, 4'b1010});
    add_vec("load_z_only", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2222, 32'h0000_3333, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0011, 4'b0001, o9);
    add_vec("stall_and_flush", 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_3333, 32'h0000_4444, 5'd6, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1111, o9);
    add_vec("flush_after_stall", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_3333, 32'h0000_4444, 5'd6, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1111,
            {1'b0, 32'h0000_3333, 32'h0000_4444, 5'd6, 1'b0, 1'b0, 1'b0, 4'b1011});
    add_vec("invalid_instr", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_4444, 32'h0000_5555, 5'd7, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1111,
            {1'b0, 32'h0000_4444, 32'h0000_5555, 5'd7, 1'b0, 1'b0, 1'b0, 4'b1011});
    add_vec("shift_v_held", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_8888, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 4'b0110, 4'b1011, o13);
    add_vec("stall_before_rst", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_9999, 32'h1, 5'd1, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111, o13);
    add_vec("reset_mid_stall", 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_9999, 32'h1, 5'd1, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111, zero_o);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    @(posedge clk);
    #1;

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].stl, vq[i].fl, vq[i].v, vq[i].res, vq[i].sd, vq[i].rd,
            vq[i].rw, vq[i].mr, vq[i].mw, vq[i].fin, vq[i].we);
      @(posedge clk);
      #1;
      check(vq[i].name, vq[i].exp);
    end

    // Randomized run; the first cycle is a forced reset so the model starts aligned.
    m = zero_o;
    for (int c = 0; c < 400; c++) begin
      r   = (c == 0) || ($urandom_range(0, 99) < 3);
      s   = ($urandom_range(0, 99) < 20);
      f   = ($urandom_range(0, 99) < 15);
      v   = ($urandom_range(0, 99) < 80);
      res = $urandom;
      sd  = $urandom;
      rd  = 5'($urandom_range(0, 31));
      rw  = 1'($urandom_range(0, 1));
      mr  = 1'($urandom_range(0, 1));
      mw  = 1'($urandom_range(0, 1));
      fin = 4'($urandom_range(0, 15));
      we  = 4'($urandom_range(0, 15));
      drive(r, s, f, v, res, sd, rd, rw, mr, mw, fin, we);
      @(posedge clk);
      #1;
      if (r) begin
        m = zero_o;
      end else if (!s) begin
        m.result = res;
        m.sd     = sd;
        m.rd     = rd;
        if (v && !f) begin
          m.valid = 1'b1;
          m.rw    = rw;
          m.mr    = mr;
          m.mw    = mw;
          for (int b = 0; b < 4; b++)
            if (we[b]) m.flags[b] = fin[b];
        end else begin
          m.valid = 1'b0;
          m.rw    = 1'b0;
          m.mr    = 1'b0;
          m.mw    = 1'b0;
        end
      end
      check($sformatf("random_%0d", c), m);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
